cdb_arbiter: RTL

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 11 +
 rtl/cdb_arbiter_if.sv | 29 ++
 rtl/cdb_arbiter_rr_select.sv | 33 +++
 rtl/cdb_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter slice.
// The optional feature is selected with the macro CDB_ROUND_ROBIN_EN.
package cdb_arbiter_pkg;
    localparam int DATA_W_DEF  = 32;
    localparam int LABEL_W_DEF = 4;
    localparam int N_REQ_DEF   = 4;
    localparam int PTR_W       = 2;

    // Tag value that consumers treat as "no producer".
    localparam logic [LABEL_W_DEF-1:0] NO_TAG = '0;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Bus between the functional units / commit side and the CDB arbiter.
// The macro CDB_ROUND_ROBIN_EN does not change this interface.
interface cdb_arbiter_if #(
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4,
    parameter int N_REQ   = 4
);
    // Handshake: a unit holds require[i] with its resultIn/labelIn stable until it
    // sees requireAC[i] in the same cycle; that rising edge is the transfer, and the
    // word appears on cdbData/cdbLabel with cdbValid high for exactly the next cycle.
    logic [N_REQ-1:0]         require;
    logic [N_REQ*DATA_W-1:0]  resultIn;
    logic [N_REQ*LABEL_W-1:0] labelIn;
    logic                     stall;
    logic [N_REQ-1:0]         requireAC;
    logic                     cdbValid;
    logic [DATA_W-1:0]        cdbData;
    logic [LABEL_W-1:0]       cdbLabel;

    modport master (
        output require, resultIn, labelIn, stall,
        input  requireAC, cdbValid, cdbData, cdbLabel
    );

    modport slave (
        input  require, resultIn, labelIn, stall,
        output requireAC, cdbValid, cdbData, cdbLabel
    );
endinterface

// File: rtl/cdb_arbiter_rr_select.sv
// One-hot grant selection: first requester at or after ptr, searching upward
// modulo N_REQ. A constant ptr of 0 turns this into fixed priority.
module rr_select
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0] require,
    input  logic [PTR_W-1:0] ptr,
    input  logic             stall,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        if (!stall) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = ptr + k[PTR_W-1:0];
                if (!grant_vld && require[idx]) begin
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                    grant_vld  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants one functional unit per cycle and broadcasts
// its result/tag one cycle later. CDB_ROUND_ROBIN_EN selects round robin, else fixed priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LABEL_W = LABEL_W_DEF,
    parameter int N_REQ   = N_REQ_DEF
) (
    input  logic             clk,
    input  logic             nRST,
    cdb_arbiter_if.slave     bus,
    output logic [PTR_W-1:0] dbg_ptr
);
    logic [N_REQ-1:0]   grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [PTR_W-1:0]   ptr_sel;

    logic               cdb_valid_d, cdb_valid_q;
    logic [DATA_W-1:0]  cdb_data_d,  cdb_data_q;
    logic [LABEL_W-1:0] cdb_label_d, cdb_label_q;

    // Reset is folded into the hold so no acknowledge escapes while nRST is low.
    rr_select #(.N_REQ(N_REQ)) u_rr_select (
        .require   (bus.require),
        .ptr       (ptr_sel),
        .stall     (bus.stall | ~nRST),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign bus.requireAC = grant;

    always_comb begin
        cdb_valid_d = grant_vld;
        cdb_data_d  = cdb_data_q;
        cdb_label_d = cdb_label_q;
        if (grant_vld) begin
            cdb_data_d  = bus.resultIn[int'(grant_idx)*DATA_W +: DATA_W];
            cdb_label_d = bus.labelIn[int'(grant_idx)*LABEL_W +: LABEL_W];
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_label_q <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_label_q <= cdb_label_d;
        end
    end

    assign bus.cdbValid = cdb_valid_q;
    assign bus.cdbData  = cdb_data_q;
    assign bus.cdbLabel = cdb_label_q;

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr_d, ptr_q;

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_sel = ptr_q;
    assign dbg_ptr = ptr_q;
`else
    assign ptr_sel = '0;
    assign dbg_ptr = '0;
`endif
endmodule
